port_uart_tx: RTL and testbench

- Peripheral at the far end of the CPU output port.
- Each `out_valid` strobe captures one 16-bit word into a small FIFO.
- Words are serialised on a UART TX line, low byte first.
- A 16-bit status word is returned for connection to the CPU input port, so software can poll for FIFO space and overflow.

---
 rtl/port_uart_pkg.sv | 17 +
 rtl/sync_fifo.sv | 56 +++++
 rtl/port_uart_tx.sv | 164 ++++++++++++++++
 tb/tb_port_uart_tx.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/port_uart_pkg.sv
// Shared types and status-word field positions for the CPU output-port UART.
package port_uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  localparam int STAT_OVF     = 15;
  localparam int STAT_BUSY    = 14;
  localparam int STAT_FULL    = 13;
  localparam int STAT_EMPTY   = 12;
  localparam int STAT_CNT_MSB = 4;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word fall-through read; a push while full is
// accepted only when a pop frees a slot on the same edge.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];
  assign count   = cnt;

  // NOTE: storage has no reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/port_uart_tx.sv
// CPU output-port peripheral: buffers 16-bit words and sends each as two
// 8N1 UART frames, low byte first, with a pollable status word.
module port_uart_tx
  import port_uart_pkg::*;
#(
  parameter int DEPTH        = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] out_data,
  input  logic        out_valid,
  input  logic        ovf_clear,
  output logic        txd,
  output logic        busy,
  output logic [15:0] status
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = $clog2(CLKS_PER_BIT);

  logic [15:0]   fifo_dout;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_pop;
  logic [AW:0]   fifo_cnt;

  tx_state_t     state, state_n;
  logic [CNTW-1:0] clk_cnt, clk_cnt_n;
  logic [2:0]    bit_idx, bit_idx_n;
  logic          hi_sel, hi_sel_n;
  logic [15:0]   shreg, shreg_n;
  logic          txd_q, txd_n;
  logic          busy_q, busy_n;
  logic          ovf_q;
  logic          push_acc;
  logic          drop;
  logic          bit_done;
  logic [7:0]    cur_byte;

  sync_fifo #(
    .WIDTH (16),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (out_valid),
    .pop   (fifo_pop),
    .din   (out_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

  assign bit_done = (clk_cnt == CNTW'(CLKS_PER_BIT - 1));
  assign cur_byte = hi_sel ? shreg[15:8] : shreg[7:0];
  assign push_acc = out_valid && (!fifo_full || fifo_pop);
  assign drop     = out_valid && fifo_full && !fifo_pop;

  // The line value is computed one edge ahead so txd comes straight off a flop.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no latches.
    state_n   = state;
    clk_cnt_n = bit_done ? '0 : clk_cnt + CNTW'(1);
    bit_idx_n = bit_idx;
    hi_sel_n  = hi_sel;
    shreg_n   = shreg;
    txd_n     = txd_q;
    fifo_pop  = 1'b0;
    case (state)
      IDLE: begin
        clk_cnt_n = '0;
        txd_n     = 1'b1;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shreg_n  = fifo_dout;
          hi_sel_n = 1'b0;
          state_n  = START;
          txd_n    = 1'b0;
        end
      end
      START: begin
        if (bit_done) begin
          state_n   = DATA;
          bit_idx_n = 3'd0;
          txd_n     = cur_byte[0];
        end
      end
      DATA: begin
        if (bit_done) begin
          if (bit_idx == 3'd7) begin
            state_n = STOP;
            txd_n   = 1'b1;
          end else begin
            bit_idx_n = bit_idx + 3'd1;
            txd_n     = cur_byte[bit_idx_n];
          end
        end
      end
      STOP: begin
        if (bit_done) begin
          if (!hi_sel) begin
            hi_sel_n = 1'b1;
            state_n  = START;
            txd_n    = 1'b0;
          end else if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shreg_n  = fifo_dout;
            hi_sel_n = 1'b0;
            state_n  = START;
            txd_n    = 1'b0;
          end else begin
            state_n = IDLE;
            txd_n   = 1'b1;
          end
        end
      end
      default: begin
        state_n = IDLE;
        txd_n   = 1'b1;
      end
    endcase
    // A pop only happens on a move to START, so an IDLE next state means the
    // FIFO will hold exactly what it holds now plus any accepted push.
    busy_n = (state_n != IDLE) || !fifo_empty || push_acc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      clk_cnt <= '0;
      bit_idx <= 3'd0;
      hi_sel  <= 1'b0;
      shreg   <= '0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state   <= state_n;
      clk_cnt <= clk_cnt_n;
      bit_idx <= bit_idx_n;
      hi_sel  <= hi_sel_n;
      shreg   <= shreg_n;
      txd_q   <= txd_n;
      busy_q  <= busy_n;
      if (drop)           ovf_q <= 1'b1;
      else if (ovf_clear) ovf_q <= 1'b0;
    end
  end

  assign txd  = txd_q;
  assign busy = busy_q;

  always_comb begin
    status                   = '0;
    status[STAT_OVF]         = ovf_q;
    status[STAT_BUSY]        = busy_q;
    status[STAT_FULL]        = fifo_full;
    status[STAT_EMPTY]       = fifo_empty;
    status[STAT_CNT_MSB:0]   = 5'(fifo_cnt);
  end

endmodule

// File: tb/tb_port_uart_tx.sv
// Self-checking bench for port_uart_tx: status vectors, a line monitor that
// decodes frames, and a scoreboard of words expected on txd.
module tb_port_uart_tx;

  localparam int CPB = 4;
  localparam int DEP = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] out_data = '0;
  logic        out_valid = 1'b0;
  logic        ovf_clear = 1'b0;
  logic        txd;
  logic        busy;
  logic [15:0] status;

  int          checks = 0;
  int          errors = 0;
  int          rx_count = 0;
  int          cyc = 0;
  logic        mon_en = 1'b0;
  logic [15:0] exp_q [$];
  int          starts [$];

  typedef struct {
    logic        valid;
    logic [15:0] data;
    logic        clr;
    logic        acc;
    logic [15:0] exp_status;
  } vec_t;

  vec_t vecs [9];

  port_uart_tx #(
    .DEPTH        (DEP),
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .out_data  (out_data),
    .out_valid (out_valid),
    .ovf_clear (ovf_clear),
    .txd       (txd),
    .busy      (busy),
    .status    (status)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  // One clock edge with the given inputs; accepted words join the scoreboard.
  task automatic drive(input logic v, input logic [15:0] d, input logic c, input logic acc);
    out_valid = v;
    out_data  = d;
    ovf_clear = c;
    if (v && acc) exp_q.push_back(d);
    @(posedge clk);
    #1;
    out_valid = 1'b0;
    ovf_clear = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 16'h0000, 1'b0, 1'b0);
  endtask

  task automatic wait_rx(input int n, input int budget);
    int k;
    k = 0;
    while (rx_count < n && k < budget) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("rx_word_count", 16'(rx_count), 16'(n));
  endtask

  // Line monitor: samples mid-bit on the falling edge, pairs bytes into words.
  initial begin
    logic [7:0]  b;
    logic [7:0]  lo;
    logic        hi;
    hi = 1'b0;
    lo = '0;
    forever begin
      @(negedge clk);
      if (mon_en && txd === 1'b0) begin
        starts.push_back(cyc);
        repeat (CPB/2) @(negedge clk);
        check("start_bit", 16'(txd), 16'h0000);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = txd;
        end
        repeat (CPB) @(negedge clk);
        check("stop_bit", 16'(txd), 16'h0001);
        if (!hi) begin
          lo = b;
          hi = 1'b1;
        end else begin
          hi = 1'b0;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rx_unexpected got %h want none", {b, lo});
          end else begin
            check("rx_word", {b, lo}, exp_q.pop_front());
          end
          rx_count++;
        end
      end
    end
  end

  initial begin
    // Overflow and clear precedence, starting idle with an empty FIFO.
    vecs[0] = '{1'b1, 16'h0101, 1'b0, 1'b1, 16'h4001};
    vecs[1] = '{1'b1, 16'h0202, 1'b0, 1'b1, 16'h4001};
    vecs[2] = '{1'b1, 16'h0303, 1'b0, 1'b1, 16'h4002};
    vecs[3] = '{1'b1, 16'h0404, 1'b0, 1'b1, 16'h4003};
    vecs[4] = '{1'b1, 16'h0505, 1'b0, 1'b1, 16'h6004};
    vecs[5] = '{1'b1, 16'h0606, 1'b0, 1'b0, 16'hE004};
    vecs[6] = '{1'b1, 16'h0707, 1'b1, 1'b0, 16'hE004};
    vecs[7] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h6004};
    vecs[8] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h6004};

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check("rst_status", status, 16'h1000);
    check("rst_txd", 16'(txd), 16'h0001);
    check("rst_busy", 16'(busy), 16'h0000);

    // Asynchronous reset in the middle of a frame.
    drive(1'b1, 16'h1234, 1'b0, 1'b0);
    idle(10);
    check("pre_rst_txd", 16'(txd), 16'h0000);
    rst_n = 1'b0;
    #1;
    check("midrst_txd", 16'(txd), 16'h0001);
    check("midrst_busy", 16'(busy), 16'h0000);
    check("midrst_status", status, 16'h1000);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    mon_en = 1'b1;

    // Single word: start bit after the pop edge, busy clears 80 clocks later.
    drive(1'b1, 16'hA55A, 1'b0, 1'b1);
    check("sw_txd_e0", 16'(txd), 16'h0001);
    check("sw_status_e0", status, 16'h4001);
    idle(1);
    check("sw_txd_e1", 16'(txd), 16'h0000);
    check("sw_status_e1", status, 16'h5000);
    idle(79);
    check("sw_busy_e80", 16'(busy), 16'h0001);
    idle(1);
    check("sw_busy_e81", 16'(busy), 16'h0000);
    check("sw_status_e81", status, 16'h1000);
    check("sw_txd_e81", 16'(txd), 16'h0001);
    wait_rx(1, 50);

    // Back-to-back words: six frames with no idle time between them.
    starts.delete();
    drive(1'b1, 16'h0001, 1'b0, 1'b1);
    check("b2b_status_0", status, 16'h4001);
    drive(1'b1, 16'h0002, 1'b0, 1'b1);
    check("b2b_status_1", status, 16'h4001);
    drive(1'b1, 16'h0003, 1'b0, 1'b1);
    check("b2b_status_2", status, 16'h4002);
    wait_rx(4, 300);
    check("b2b_frames", 16'(starts.size()), 16'd6);
    for (int i = 1; i < starts.size(); i++)
      check("b2b_gap", 16'(starts[i] - starts[i-1]), 16'(10*CPB));
    idle(4);
    check("b2b_drained", status, 16'h1000);

    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].valid, vecs[i].data, vecs[i].clr, vecs[i].acc);
      check($sformatf("ovf_vec%0d", i), status, vecs[i].exp_status);
    end
    wait_rx(9, 500);
    idle(4);
    check("ovf_drained", status, 16'h1000);

    // Full FIFO with a push landing on the STOP-to-START pop edge.
    drive(1'b1, 16'h1111, 1'b0, 1'b1);
    drive(1'b1, 16'h2222, 1'b0, 1'b1);
    drive(1'b1, 16'h3333, 1'b0, 1'b1);
    drive(1'b1, 16'h4444, 1'b0, 1'b1);
    drive(1'b1, 16'h5555, 1'b0, 1'b1);
    check("fwp_full", status, 16'h6004);
    idle(76);
    check("fwp_pre_pop", status, 16'h6004);
    drive(1'b1, 16'h6666, 1'b0, 1'b1);
    check("fwp_push_pop", status, 16'h6004);
    wait_rx(15, 600);
    idle(4);
    check("fwp_drained", status, 16'h1000);
    check("scoreboard_empty", 16'(exp_q.size()), 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
